// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - encodes operations into MIPS words and writes them sequentially to instruction memory
module inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [15:0]       imm,
  input  logic [31:0]       target,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {IDLE, RUN, ENC, WR, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [3:0]        mnem_q;
  logic [4:0]        rd_q, rs_q, rt_q;
  logic [15:0]       imm_q;
  logic [31:0]       tgt_q;
  logic              last_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q, err_q;
  logic [1:0]        code_q;

  logic [31:0] pc, pc4, diff, word;
  logic        algn_bad, jmp_bad, br_ok, illegal, tgt_bad, restart;

  assign pc  = 32'(ptr) << 2;
  assign pc4 = pc + 32'd4;
  // pc4 is word aligned, so the low bits of diff are exactly target[1:0]
  assign diff     = tgt_q - pc4;
  assign algn_bad = |diff[1:0];
  assign jmp_bad  = tgt_q[31:28] != pc4[31:28];
  assign br_ok    = (&diff[31:17]) | ~(|diff[31:17]);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    tgt_bad = 1'b0;
    case (mnem_q)
      4'd0:  word = {6'd0, rs_q, rt_q, rd_q, 5'd0, 6'd32};
      4'd1:  word = {6'd0, rs_q, rt_q, rd_q, 5'd0, 6'd34};
      4'd2:  word = {6'd0, rs_q, rt_q, rd_q, 5'd0, 6'd42};
      4'd3:  word = {6'd0, rs_q, 15'd0, 6'd8};
      4'd4:  word = {6'd8, rs_q, rt_q, imm_q};
      4'd5:  word = {6'd10, rs_q, rt_q, imm_q};
      4'd6:  word = {6'd35, rs_q, rt_q, imm_q};
      4'd7:  word = {6'd43, rs_q, rt_q, imm_q};
      4'd8: begin
        word    = {6'd2, tgt_q[27:2]};
        tgt_bad = algn_bad | jmp_bad;
      end
      4'd9: begin
        word    = {6'd3, tgt_q[27:2]};
        tgt_bad = algn_bad | jmp_bad;
      end
      4'd10: begin
        word    = {6'd4, rs_q, rt_q, diff[17:2]};
        tgt_bad = algn_bad | ~br_ok;
      end
      4'd11: begin
        word    = {6'd5, rs_q, rt_q, diff[17:2]};
        tgt_bad = algn_bad | ~br_ok;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign restart = start & (state == IDLE || state == DONE || state == ERR);

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) nxt = RUN;
      RUN:             if (in_valid) nxt = ENC;
      ENC:             nxt = (illegal || tgt_bad) ? ERR : WR;
      WR: begin
        if (last_q)              nxt = DONE;
        else if (ptr == PTR_MAX) nxt = ERR;
        else                     nxt = RUN;
      end
      default:         nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= BASE;
      cnt     <= '0;
      mnem_q  <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      tgt_q   <= '0;
      last_q  <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state <= nxt;
      if (restart) begin
        ptr    <= BASE;
        cnt    <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
        code_q <= '0;
      end
      if (state == RUN && in_valid) begin
        mnem_q <= mnem;
        rd_q   <= rd;
        rs_q   <= rs;
        rt_q   <= rt;
        imm_q  <= imm;
        tgt_q  <= target;
        last_q <= last;
      end
      if (state == ENC) begin
        wdata_q <= word;
        addr_q  <= ptr;
        if (illegal) begin
          err_q  <= 1'b1;
          code_q <= 2'd1;
        end else if (tgt_bad) begin
          err_q  <= 1'b1;
          code_q <= 2'd2;
        end
      end
      if (state == WR) begin
        cnt <= cnt + CNT_ONE;
        // the top word is still written, but the pointer parks there instead of wrapping
        if (ptr != PTR_MAX) ptr <= ptr + PTR_ONE;
        if (last_q) begin
          done_q <= 1'b1;
        end else if (ptr == PTR_MAX) begin
          err_q  <= 1'b1;
          code_q <= 2'd3;
        end
      end
    end
  end

  assign in_ready  = (state == RUN);
  assign mem_we    = (state == WR);
  assign busy      = (state == RUN) || (state == ENC) || (state == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign count     = cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed scoreboard bench for inst_encoder
module tb_inst_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, last;
  logic [3:0] mnem;
  logic [4:0] rd, rs, rt;
  logic [15:0] imm;
  logic [31:0] target;

  logic in_ready, mem_we, busy, done, err;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0] err_code;
  logic [8:0] count;

  logic in_ready2, mem_we2, busy2, done2, err2;
  logic [1:0] mem_addr2;
  logic [31:0] mem_wdata2;
  logic [1:0] err_code2;
  logic [2:0] count2;

  inst_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .target(target), .last(last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .count(count)
  );

  inst_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .mnem(mnem), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .target(target), .last(last),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2),
    .done(done2), .err(err2), .err_code(err_code2), .count(count2)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] w;
    logic [31:0] c;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int fails = 0;
  logic [31:0] cyc = '0;
  bit en2 = 1'b0;
  logic [7:0] eptr = '0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      exp_t e;
      chk("write_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e.a));
        chk("write_data", mem_wdata, e.w);
        chk("write_cycle", cyc, e.c);
      end
    end
    if (en2 && mem_we2 !== 1'b0) begin
      exp_t e;
      chk("w2_expected", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("w2_addr", 32'(mem_addr2), 32'(e.a));
        chk("w2_data", mem_wdata2, e.w);
      end
    end
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_err"}, 32'(err), 32'd0);
    chk({pfx, "_err_code"}, 32'(err_code), 32'd0);
    chk({pfx, "_count"}, 32'(count), 32'd0);
    chk({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    eptr = '0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clr", {30'd0, err, done}, 32'd0);
    chk("start_code_clr", 32'(err_code), 32'd0);
  endtask

  task automatic send(input logic [3:0] mn, input logic [4:0] d, input logic [4:0] s,
                      input logic [4:0] t, input logic [15:0] im, input logic [31:0] tg,
                      input logic l, input bit push, input logic [31:0] w);
    @(negedge clk);
    mnem = mn; rd = d; rs = s; rt = t; imm = im; target = tg; last = l;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) break;
      @(negedge clk);
    end
    chk("accept", 32'(in_ready), 32'd1);
    if (push) begin
      q1.push_back('{a: eptr, w: w, c: cyc + 32'd2});
      if (en2) q2.push_back('{a: eptr, w: w, c: cyc + 32'd2});
      eptr++;
    end
    @(negedge clk) in_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1 || err === 1'b1) break;
      @(negedge clk);
    end
    chk("end_reached", 32'(done | err), 32'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    mnem = '0; rd = '0; rs = '0; rt = '0; imm = '0; target = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // two-instruction program
    do_start();
    send(4'd0, 5'd3, 5'd1, 5'd2, 16'd0, 32'd0, 1'b0, 1'b1, 32'h00221820);
    send(4'd4, 5'd0, 5'd0, 5'd5, 16'd7, 32'd0, 1'b1, 1'b1, 32'h20050007);
    wait_end();
    chk("p1_done", 32'(done), 32'd1);
    chk("p1_count", 32'(count), 32'd2);
    chk("p1_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("p1_done_hold", 32'(done), 32'd1);

    // branches at words 2 and 3
    do_start();
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 32'd0, 1'b0, 1'b1, 32'h00A62022);
    send(4'd2, 5'd7, 5'd8, 5'd9, 16'd0, 32'd0, 1'b0, 1'b1, 32'h0109382A);
    send(4'd10, 5'd0, 5'd1, 5'd2, 16'd0, 32'h20, 1'b0, 1'b1, 32'h10220005);
    send(4'd11, 5'd0, 5'd1, 5'd2, 16'd0, 32'h0, 1'b1, 1'b1, 32'h1422FFFC);
    wait_end();
    chk("p2_count", 32'(count), 32'd4);

    // jumps and memory ops
    do_start();
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 32'h40, 1'b0, 1'b1, 32'h0C000010);
    send(4'd6, 5'd0, 5'd29, 5'd8, 16'hFFFC, 32'd0, 1'b0, 1'b1, 32'h8FA8FFFC);
    send(4'd7, 5'd0, 5'd29, 5'd9, 16'h0004, 32'd0, 1'b0, 1'b1, 32'hAFA90004);
    send(4'd3, 5'd7, 5'd31, 5'd6, 16'h1234, 32'hFF, 1'b1, 1'b1, 32'h03E00008);
    wait_end();
    chk("p3_done", 32'(done), 32'd1);

    // illegal mnemonic
    do_start();
    send(4'd0, 5'd3, 5'd1, 5'd2, 16'd0, 32'd0, 1'b0, 1'b1, 32'h00221820);
    send(4'd15, 5'd1, 5'd1, 5'd1, 16'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    wait_end();
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_code", 32'(err_code), 32'd1);
    chk("ill_count", 32'(count), 32'd1);
    repeat (5) @(negedge clk);
    chk("ill_err_hold", 32'(err), 32'd1);
    chk("ill_code_hold", 32'(err_code), 32'd1);

    // misaligned, out-of-range and cross-region targets
    do_start();
    send(4'd10, 5'd0, 5'd1, 5'd2, 16'd0, 32'h22, 1'b0, 1'b0, 32'd0);
    wait_end();
    chk("align_code", 32'(err_code), 32'd2);
    chk("align_count", 32'(count), 32'd0);
    do_start();
    send(4'd10, 5'd0, 5'd1, 5'd2, 16'd0, 32'h40000, 1'b0, 1'b0, 32'd0);
    wait_end();
    chk("range_code", 32'(err_code), 32'd2);
    do_start();
    send(4'd8, 5'd0, 5'd0, 5'd0, 16'd0, 32'h10000000, 1'b0, 1'b0, 32'd0);
    wait_end();
    chk("region_code", 32'(err_code), 32'd2);

    // memory full on the 2-bit instance
    do_start();
    en2 = 1'b1;
    for (int i = 0; i < 4; i++)
      send(4'd0, 5'(i), 5'd1, 5'd2, 16'd0, 32'd0, 1'b0, 1'b1,
           {6'd0, 5'd1, 5'd2, 5'(i), 5'd0, 6'd32});
    for (int i = 0; i < 20; i++) begin
      if (err2 === 1'b1) break;
      @(negedge clk);
    end
    chk("full_err", 32'(err2), 32'd1);
    chk("full_code", 32'(err_code2), 32'd3);
    chk("full_count", 32'(count2), 32'd4);
    en2 = 1'b0;
    send(4'd0, 5'd9, 5'd1, 5'd2, 16'd0, 32'd0, 1'b1, 1'b1, 32'h00224820);
    wait_end();
    chk("wide_count", 32'(count), 32'd5);

    // reset during ENC with in_valid held
    do_start();
    @(negedge clk);
    mnem = 4'd0; rd = 5'd3; rs = 5'd1; rt = 5'd2; imm = '0; target = '0; last = 1'b1;
    in_valid = 1'b1;
    chk("rst_pre_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("rst_in_enc", 32'(busy & ~in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    eptr = '0;
    chk("restart_ready", 32'(in_ready), 32'd1);
    q1.push_back('{a: 8'd0, w: 32'h00221820, c: cyc + 32'd2});
    @(negedge clk) in_valid = 1'b0;
    wait_end();
    chk("restart_count", 32'(count), 32'd1);

    repeat (4) @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
